// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_arbiter                                                 |
// | Description : Writeback arbiter driving the single register-file write   |
// |               port. Merges the fixed-timing pipeline WB result with      |
// |               long-latency results that arrive on a valid/ready          |
// |               handshake and are buffered in a small FIFO. A younger      |
// |               pipeline write to the same destination kills older         |
// |               buffered entries. A pending-destination mask is exported   |
// |               for hazard detection.                                      |
// | Options     : `define WB_BYPASS_EN forwards an accepted ext result       |
// |               straight to the output stage when the FIFO is empty and    |
// |               no pipe write wins.                                        |
// | Ports       : clk, rst            clock, synchronous active-high reset   |
// |               pipe_we/rd/data     pipeline writeback (no backpressure)   |
// |               ext_valid/ready     long-latency handshake                 |
// |               ext_rd/ext_data     long-latency destination and result    |
// |               rf_we/addr/data     registered register-file write port    |
// |               pend_mask           destinations of live FIFO entries      |
// |               stall_req           ask upstream to withhold pipe_we       |
// |               fifo_count          occupied FIFO slots (live or killed)   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_rd,
    input  logic [63:0]                   pipe_data,
    input  logic                          ext_valid,
    output logic                          ext_ready,
    input  logic [4:0]                    ext_rd,
    input  logic [63:0]                   ext_data,
    output logic                          rf_we,
    output logic [4:0]                    rf_addr,
    output logic [63:0]                   rf_data,
    output logic [31:0]                   pend_mask,
    output logic                          stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_DEPTH      = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

    // FIFO storage and state
    logic [4:0]             r_rd   [FIFO_DEPTH];
    logic [63:0]            r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_live;
    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    logic [CW-1:0]          r_count;
    logic [SW-1:0]          r_starve;
    logic                   r_stall;
    logic                   r_rf_we;
    logic [4:0]             r_rf_addr;
    logic [63:0]            r_rf_data;

    logic                   w_pipe_win;
    logic                   w_xfer;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_head_live;
    logic                   w_bypass;
    logic                   w_push;
    logic                   w_push_live;
    logic [FIFO_DEPTH-1:0]  w_live_next;
    logic [SW-1:0]          w_starve_next;
    logic [31:0]            w_pend;

    // A pipe write to x0 is treated exactly like no pipe write at all.
    assign w_pipe_win  = pipe_we && (pipe_rd != 5'd0);
    assign ext_ready   = (r_count < C_DEPTH);
    assign w_xfer      = ext_valid && ext_ready;
    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_pipe_win && !w_empty;
    assign w_head_live = r_live[r_head];

`ifdef WB_BYPASS_EN
    assign w_bypass = w_xfer && w_empty && !w_pipe_win && (ext_rd != 5'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // x0 results are accepted and discarded; bypassed results skip the FIFO.
    assign w_push      = w_xfer && (ext_rd != 5'd0) && !w_bypass;
    // The concurrent pipe write to the same register is the younger one.
    assign w_push_live = !(w_pipe_win && (pipe_rd == ext_rd));

    // Live-bit update order: kill, then pop, then push. Push and pop never
    // target the same slot because a full FIFO refuses new data.
    always_comb begin
        w_live_next = r_live;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_pipe_win && (r_rd[i] == pipe_rd)) begin
                w_live_next[i] = 1'b0;
            end
        end
        if (w_pop) begin
            w_live_next[r_head] = 1'b0;
        end
        if (w_push) begin
            w_live_next[r_tail] = w_push_live;
        end
    end

    // Starvation only accrues while a live head is held off by the pipe.
    always_comb begin
        w_starve_next = '0;
        if (!w_empty && w_head_live && w_pipe_win) begin
            w_starve_next = (r_starve == C_STARVE_MAX) ? r_starve : r_starve + 1'b1;
        end
    end

    // Free and killed slots always carry live=0, so every slot can be scanned.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_live[i]) begin
                w_pend[r_rd[i]] = 1'b1;
            end
        end
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_live    <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_live   <= w_live_next;
            r_starve <= w_starve_next;
            r_stall  <= (w_starve_next >= C_STARVE_MAX);

            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Output stage: a killed head pops silently with rf_we low.
            r_rf_we <= 1'b0;
            if (w_pipe_win) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= pipe_rd;
                r_rf_data <= pipe_data;
            end else if (w_bypass) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= ext_rd;
                r_rf_data <= ext_data;
            end else if (w_pop && w_head_live) begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= r_rd[r_head];
                r_rf_data <= r_data[r_head];
            end
        end
    end

    // Payload storage needs no reset: it is qualified by the live bits.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= ext_rd;
            r_data[r_tail] <= ext_data;
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_addr    = r_rf_addr;
    assign rf_data    = r_rf_data;
    assign pend_mask  = w_pend;
    assign stall_req  = r_stall;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_arbiter                                              |
// | Description : Directed self-checking bench for wb_arbiter (default       |
// |               parameters). Follows WB_BYPASS_EN when it is defined.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_data;
    logic        ext_valid;
    logic        ext_ready;
    logic [4:0]  ext_rd;
    logic [63:0] ext_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic [31:0] pend_mask;
    logic        stall_req;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .ext_rd     (ext_rd),
        .ext_data   (ext_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .pend_mask  (pend_mask),
        .stall_req  (stall_req),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [63:0] d);
        pipe_we = we; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic set_ext(input logic v, input logic [4:0] rd, input logic [63:0] d);
        ext_valid = v; ext_rd = rd; ext_data = d;
    endtask

    initial begin
        rst = 1'b1;
        set_pipe(1'b0, 5'd0, 64'd0);
        set_ext(1'b0, 5'd0, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rf_we",     rf_we,      0);
        check("rst_rf_addr",   rf_addr,    0);
        check("rst_rf_data",   rf_data,    0);
        check("rst_count",     fifo_count, 0);
        check("rst_pend",      pend_mask,  0);
        check("rst_stall",     stall_req,  0);
        check("rst_ready",     ext_ready,  1);

        // Single pipe write
        set_pipe(1'b1, 5'd5, 64'hAA);
        tick();
        set_pipe(1'b0, 5'd0, 64'd0);
        check("pipe_we",   rf_we,   1);
        check("pipe_addr", rf_addr, 5);
        check("pipe_data", rf_data, 64'hAA);
        tick();
        check("pipe_we_drop", rf_we, 0);

        // Single ext result on an idle pipe
        set_ext(1'b1, 5'd7, 64'h1234);
        tick();
        set_ext(1'b0, 5'd0, 64'd0);
`ifdef WB_BYPASS_EN
        check("byp_we",   rf_we,     1);
        check("byp_addr", rf_addr,   7);
        check("byp_data", rf_data,   64'h1234);
        check("byp_pend", pend_mask, 0);
        check("byp_cnt",  fifo_count, 0);
        tick();
        check("byp_we_drop", rf_we, 0);
        check("byp_pend2",   pend_mask, 0);
`else
        check("ext_we0",   rf_we,      0);
        check("ext_pend",  pend_mask,  32'h80);
        check("ext_cnt1",  fifo_count, 1);
        tick();
        check("ext_we",    rf_we,      1);
        check("ext_addr",  rf_addr,    7);
        check("ext_data",  rf_data,    64'h1234);
        check("ext_pend0", pend_mask,  0);
        check("ext_cnt0",  fifo_count, 0);
        tick();
        check("ext_we_drop", rf_we, 0);
`endif

        // Fill the FIFO behind a continuous pipe stream (pointers wrap later)
        set_pipe(1'b1, 5'd20, 64'hF0);
        for (int i = 1; i <= 4; i++) begin
            set_ext(1'b1, 5'(i), 64'h100 + 64'(i));
            tick();
            check("fill_addr", rf_addr, 20);
        end
        set_ext(1'b0, 5'd0, 64'd0);
        check("full_cnt",   fifo_count, 4);
        check("full_ready", ext_ready,  0);
        check("full_pend",  pend_mask,  32'h1E);
        check("full_stall", stall_req,  0);
        // Counter: 0 after edge 1, reaches 7 after edge 8 and 8 after edge 9.
        for (int i = 0; i < 4; i++) tick();
        check("starve7_stall", stall_req, 0);
        tick();
        check("starve8_stall", stall_req, 1);
        check("starve8_we",    rf_we,     1);
        check("starve8_addr",  rf_addr,   20);
        // Pipe still wins while stall_req is high
        set_pipe(1'b1, 5'd21, 64'hF1);
        tick();
        check("stall_pipe_addr", rf_addr, 21);
        check("stall_pipe_data", rf_data, 64'hF1);
        check("stall_cnt",       fifo_count, 4);
        check("stall_held",      stall_req, 1);
        // Drain in order on consecutive cycles
        set_pipe(1'b0, 5'd0, 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_we",   rf_we,      1);
            check("drain_addr", rf_addr,    64'(i));
            check("drain_data", rf_data,    64'h100 + 64'(i));
            check("drain_cnt",  fifo_count, 64'(4 - i));
            check("drain_rdy",  ext_ready,  1);
        end
        check("drain_stall", stall_req, 0);
        check("drain_pend",  pend_mask, 0);
        tick();
        check("drain_idle", rf_we, 0);

        // Kill: x9 enqueued behind a pipe write, then overwritten by the pipe
        set_pipe(1'b1, 5'd10, 64'h10);
        set_ext(1'b1, 5'd9, 64'h99);
        tick();
        set_ext(1'b0, 5'd0, 64'd0);
        check("kill_pend_set", pend_mask, 32'h200);
        check("kill_addr10",   rf_addr,   10);
        set_pipe(1'b1, 5'd9, 64'h55);
        tick();
        set_pipe(1'b0, 5'd0, 64'd0);
        check("kill_addr",  rf_addr,    9);
        check("kill_data",  rf_data,    64'h55);
        check("kill_pend",  pend_mask,  0);
        check("kill_cnt",   fifo_count, 1);
        tick();
        check("kill_pop_we",  rf_we,      0);
        check("kill_pop_cnt", fifo_count, 0);

        // Same-cycle ext and pipe to x3: pipe is younger
        set_pipe(1'b1, 5'd3, 64'h33);
        set_ext(1'b1, 5'd3, 64'hEE);
        tick();
        set_pipe(1'b0, 5'd0, 64'd0);
        set_ext(1'b0, 5'd0, 64'd0);
        check("same_we",   rf_we,      1);
        check("same_data", rf_data,    64'h33);
        check("same_cnt",  fifo_count, 1);
        check("same_pend", pend_mask,  0);
        tick();
        check("same_pop_we",  rf_we,      0);
        check("same_pop_cnt", fifo_count, 0);

        // x0 traffic on both sources
        set_pipe(1'b1, 5'd0, 64'h77);
        set_ext(1'b1, 5'd0, 64'h88);
        tick();
        set_pipe(1'b0, 5'd0, 64'd0);
        set_ext(1'b0, 5'd0, 64'd0);
        check("x0_we",  rf_we,      0);
        check("x0_cnt", fifo_count, 0);
        tick();
        check("x0_we2", rf_we, 0);

        // Reset with three entries queued
        set_pipe(1'b1, 5'd22, 64'h22);
        for (int i = 0; i < 3; i++) begin
            set_ext(1'b1, 5'(11 + i), 64'h200 + 64'(i));
            tick();
        end
        set_pipe(1'b0, 5'd0, 64'd0);
        set_ext(1'b0, 5'd0, 64'd0);
        check("pre_rst_cnt",  fifo_count, 3);
        check("pre_rst_pend", pend_mask,  32'h3800);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_we",   rf_we,      0);
        check("mid_rst_cnt",  fifo_count, 0);
        check("mid_rst_pend", pend_mask,  0);
        tick();
        check("post_rst_we",  rf_we,      0);
        check("post_rst_cnt", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
